// File: rtl/issue_sched_pkg.sv
// Shared types and constants for the unified issue queue and its select logic.
package issue_sched_pkg;

    localparam int unsigned PTAG_W = 7;
    localparam int unsigned FU_W   = 3;

    localparam logic [FU_W-1:0] FU_ALU = 3'd0;
    localparam logic [FU_W-1:0] FU_MUL = 3'd1;
    localparam logic [FU_W-1:0] FU_DIV = 3'd2;
    localparam logic [FU_W-1:0] FU_BR  = 3'd3;
    localparam logic [FU_W-1:0] FU_LD  = 3'd4;
    localparam logic [FU_W-1:0] FU_ST  = 3'd5;
    localparam logic [FU_W-1:0] FU_FPU = 3'd6;
    localparam logic [FU_W-1:0] FU_CSR = 3'd7;

    typedef enum logic {
        ST_FREE = 1'b0,
        ST_WAIT = 1'b1
    } ent_st_t;

    // Tag/readiness part of an entry; rob slot and payload live in side arrays
    typedef struct packed {
        ent_st_t           st;
        logic              r1;
        logic              r2;
        logic [PTAG_W-1:0] rs1;
        logic [PTAG_W-1:0] rs2;
        logic [FU_W-1:0]   fu_sel;
    } iq_entry_t;

endpackage

// File: rtl/iq_age_select.sv
// Oldest-eligible picker: smallest (rob_idx - rob_head) wins, lowest index on ties.
module iq_age_select #(
    parameter int unsigned N  = 8,
    parameter int unsigned RW = 5
) (
    input  logic [N-1:0]           elig_i,
    input  logic [N-1:0][RW-1:0]   rob_idx_i,
    input  logic [RW-1:0]          rob_head_i,
    output logic [N-1:0]           grant_o,
    output logic [$clog2(N)-1:0]   idx_o,
    output logic                   any_o
);
    localparam int unsigned IW = $clog2(N);

    logic          found;
    logic [RW-1:0] age;
    logic [RW-1:0] best;
    logic [IW-1:0] idx;

    always_comb begin
        found = 1'b0;
        age   = '0;
        best  = '0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            // modular subtraction keeps the ordering correct across the rob wrap
            age = rob_idx_i[i] - rob_head_i;
            if (elig_i[i] && (!found || age < best)) begin
                found = 1'b1;
                best  = age;
                idx   = IW'(i);
            end
        end
        idx_o   = idx;
        any_o   = found;
        grant_o = found ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/issue_sched.sv
// Unified issue queue: holds renamed micro-ops, wakes them on writeback tags,
// and issues the oldest ready one whose functional unit is free.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int unsigned IQ_LEN    = 8,
    parameter int unsigned ROB_LEN   = 32,
    parameter int unsigned WK_PORTS  = 2,
    parameter int unsigned PAYLOAD_W = 96
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [PTAG_W-1:0]             enq_rs1,
    input  logic [PTAG_W-1:0]             enq_rs2,
    input  logic                          enq_rs1_rdy,
    input  logic                          enq_rs2_rdy,
    input  logic [FU_W-1:0]               enq_fu_sel,
    input  logic [$clog2(ROB_LEN)-1:0]    enq_rob_idx,
    input  logic [PAYLOAD_W-1:0]          enq_payload,
    input  logic [WK_PORTS-1:0]           wk_valid,
    input  logic [WK_PORTS*PTAG_W-1:0]    wk_tag,
    input  logic [7:0]                    fu_busy,
    input  logic [$clog2(ROB_LEN)-1:0]    rob_head,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [PTAG_W-1:0]             issue_rs1,
    output logic [PTAG_W-1:0]             issue_rs2,
    output logic [FU_W-1:0]               issue_fu_sel,
    output logic [$clog2(ROB_LEN)-1:0]    issue_rob_idx,
    output logic [PAYLOAD_W-1:0]          issue_payload,
    output logic [$clog2(IQ_LEN):0]       iq_count,
    output logic                          iq_empty
);
    localparam int unsigned RW = $clog2(ROB_LEN);
    localparam int unsigned IW = $clog2(IQ_LEN);
    localparam int unsigned CW = IW + 1;

    iq_entry_t              ent_q [IQ_LEN];
    iq_entry_t              ent_d [IQ_LEN];
    logic [RW-1:0]          rob_q [IQ_LEN];
    logic [PAYLOAD_W-1:0]   pay_q [IQ_LEN];
    logic [CW-1:0]          count_q, count_d;

    logic [IQ_LEN-1:0]          elig_c, grant_c;
    logic [IQ_LEN-1:0][RW-1:0]  rob_flat_c;
    logic [IW-1:0]              sel_c, free_idx_c;
    logic                       any_c, enq_fire_c, issue_fire_c;

    function automatic logic woken(input logic [WK_PORTS-1:0] v,
                                   input logic [WK_PORTS*PTAG_W-1:0] t,
                                   input logic [PTAG_W-1:0] tag);
        woken = 1'b0;
        for (int p = 0; p < int'(WK_PORTS); p++)
            if (v[p] && t[p*PTAG_W +: PTAG_W] == tag) woken = 1'b1;
    endfunction

    assign enq_ready    = count_q < CW'(IQ_LEN);
    assign enq_fire_c   = enq_valid && enq_ready && !flush && !rst;
    assign issue_valid  = any_c && !flush && !rst;
    assign issue_fire_c = issue_valid && issue_ready;

    // Lowest-index free slot
    always_comb begin
        free_idx_c = '0;
        for (int i = int'(IQ_LEN) - 1; i >= 0; i--)
            if (ent_q[i].st == ST_FREE) free_idx_c = IW'(i);
    end

    always_comb begin
        for (int i = 0; i < int'(IQ_LEN); i++) begin
            rob_flat_c[i] = rob_q[i];
            elig_c[i] = (ent_q[i].st == ST_WAIT) && ent_q[i].r1 && ent_q[i].r2
                        && !fu_busy[ent_q[i].fu_sel];
        end
    end

    iq_age_select #(.N(IQ_LEN), .RW(RW)) u_sel (
        .elig_i     (elig_c),
        .rob_idx_i  (rob_flat_c),
        .rob_head_i (rob_head),
        .grant_o    (grant_c),
        .idx_o      (sel_c),
        .any_o      (any_c)
    );

    // Per-entry FREE/WAIT transitions plus wakeup
    always_comb begin
        for (int i = 0; i < int'(IQ_LEN); i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].st == ST_WAIT) begin
                ent_d[i].r1 = ent_q[i].r1 | woken(wk_valid, wk_tag, ent_q[i].rs1);
                ent_d[i].r2 = ent_q[i].r2 | woken(wk_valid, wk_tag, ent_q[i].rs2);
                if (issue_fire_c && grant_c[i]) ent_d[i].st = ST_FREE;
            end else if (enq_fire_c && free_idx_c == IW'(i)) begin
                ent_d[i].st     = ST_WAIT;
                ent_d[i].rs1    = enq_rs1;
                ent_d[i].rs2    = enq_rs2;
                ent_d[i].fu_sel = enq_fu_sel;
                ent_d[i].r1     = enq_rs1_rdy || (enq_rs1 == '0) || woken(wk_valid, wk_tag, enq_rs1);
                ent_d[i].r2     = enq_rs2_rdy || (enq_rs2 == '0) || woken(wk_valid, wk_tag, enq_rs2);
            end
        end
        count_d = count_q + CW'(enq_fire_c) - CW'(issue_fire_c);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < int'(IQ_LEN); i++) ent_q[i] <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            count_q <= count_d;
        end
    end

    // Opaque data needs no reset: it is only visible through a valid entry
    always_ff @(posedge clk) begin
        if (enq_fire_c) begin
            rob_q[free_idx_c] <= enq_rob_idx;
            pay_q[free_idx_c] <= enq_payload;
        end
    end

    assign issue_rs1     = issue_valid ? ent_q[sel_c].rs1    : '0;
    assign issue_rs2     = issue_valid ? ent_q[sel_c].rs2    : '0;
    assign issue_fu_sel  = issue_valid ? ent_q[sel_c].fu_sel : '0;
    assign issue_rob_idx = issue_valid ? rob_q[sel_c]        : '0;
    assign issue_payload = issue_valid ? pay_q[sel_c]        : '0;
    assign iq_count      = count_q;
    assign iq_empty      = (count_q == '0);

endmodule

// File: tb/tb_issue_sched.sv
// Directed and random checks of issue_sched against a queue-based reference model.
module tb_issue_sched;
    import issue_sched_pkg::*;

    localparam int IQ   = 8;
    localparam int ROBL = 32;
    localparam int WKP  = 2;
    localparam int PW   = 96;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, enq_valid, enq_ready;
    logic [6:0]      enq_rs1, enq_rs2;
    logic            enq_rs1_rdy, enq_rs2_rdy;
    logic [2:0]      enq_fu_sel;
    logic [4:0]      enq_rob_idx;
    logic [PW-1:0]   enq_payload;
    logic [WKP-1:0]  wk_valid;
    logic [WKP*7-1:0] wk_tag;
    logic [7:0]      fu_busy;
    logic [4:0]      rob_head;
    logic            issue_valid, issue_ready;
    logic [6:0]      issue_rs1, issue_rs2;
    logic [2:0]      issue_fu_sel;
    logic [4:0]      issue_rob_idx;
    logic [PW-1:0]   issue_payload;
    logic [3:0]      iq_count;
    logic            iq_empty;

    issue_sched #(.IQ_LEN(IQ), .ROB_LEN(ROBL), .WK_PORTS(WKP), .PAYLOAD_W(PW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
        .enq_rs1_rdy(enq_rs1_rdy), .enq_rs2_rdy(enq_rs2_rdy),
        .enq_fu_sel(enq_fu_sel), .enq_rob_idx(enq_rob_idx), .enq_payload(enq_payload),
        .wk_valid(wk_valid), .wk_tag(wk_tag), .fu_busy(fu_busy), .rob_head(rob_head),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_fu_sel(issue_fu_sel),
        .issue_rob_idx(issue_rob_idx), .issue_payload(issue_payload),
        .iq_count(iq_count), .iq_empty(iq_empty)
    );

    typedef struct {
        logic [6:0]    rs1, rs2;
        bit            r1, r2;
        logic [2:0]    fu;
        logic [4:0]    rob;
        logic [PW-1:0] pay;
    } m_ent_t;

    m_ent_t mq[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_wake(input logic [6:0] tag);
        for (int p = 0; p < WKP; p++)
            if (wk_valid[p] && wk_tag[p*7 +: 7] == tag) return 1'b1;
        return 1'b0;
    endfunction

    // Oldest (by distance from rob_head) resident op with both sources ready and a free FU
    function automatic int m_pick();
        int best = -1;
        int best_age = ROBL;
        int age;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2 && !fu_busy[mq[i].fu]) begin
                age = (int'(mq[i].rob) - int'(rob_head) + ROBL) % ROBL;
                if (age < best_age) begin
                    best_age = age;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic settle();
        int w;
        bit exp_iv;
        #1;
        w = m_pick();
        exp_iv = (w >= 0) && !flush && !rst;
        chk("enq_ready", enq_ready, mq.size() < IQ);
        chk("iq_count", iq_count, mq.size());
        chk("iq_empty", iq_empty, mq.size() == 0);
        chk("issue_valid", issue_valid, exp_iv);
        if (exp_iv) begin
            chk("issue_rs1", issue_rs1, mq[w].rs1);
            chk("issue_rs2", issue_rs2, mq[w].rs2);
            chk("issue_fu", issue_fu_sel, mq[w].fu);
            chk("issue_rob", issue_rob_idx, mq[w].rob);
            chk("issue_pay", issue_payload, mq[w].pay);
        end else begin
            chk("idle_data", {issue_rs1, issue_rs2, issue_fu_sel, issue_rob_idx}, 0);
            chk("idle_pay", issue_payload, 0);
        end
    endtask

    task automatic tick();
        int w;
        bit ev, fire;
        m_ent_t nq[$];
        m_ent_t ne;
        w    = m_pick();
        ev   = enq_valid && (mq.size() < IQ) && !flush && !rst;
        fire = (w >= 0) && !flush && !rst && issue_ready;
        nq   = mq;
        if (rst || flush) nq.delete();
        else begin
            for (int i = 0; i < nq.size(); i++) begin
                nq[i].r1 = nq[i].r1 | m_wake(nq[i].rs1);
                nq[i].r2 = nq[i].r2 | m_wake(nq[i].rs2);
            end
            if (fire) nq.delete(w);
            if (ev) begin
                ne.rs1 = enq_rs1; ne.rs2 = enq_rs2; ne.fu = enq_fu_sel;
                ne.rob = enq_rob_idx; ne.pay = enq_payload;
                ne.r1 = enq_rs1_rdy || enq_rs1 == 0 || m_wake(enq_rs1);
                ne.r2 = enq_rs2_rdy || enq_rs2 == 0 || m_wake(enq_rs2);
                nq.push_back(ne);
            end
        end
        @(posedge clk);
        mq = nq;
        @(negedge clk);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic idle();
        rst = 0; flush = 0; enq_valid = 0; wk_valid = '0; wk_tag = '0;
        enq_rs1 = 0; enq_rs2 = 0; enq_rs1_rdy = 0; enq_rs2_rdy = 0;
        enq_fu_sel = 0; enq_rob_idx = 0; enq_payload = '0;
    endtask

    task automatic enq(input logic [6:0] t1, input bit r1, input logic [6:0] t2, input bit r2,
                       input logic [2:0] fu, input logic [4:0] rob);
        enq_valid = 1; enq_rs1 = t1; enq_rs1_rdy = r1; enq_rs2 = t2; enq_rs2_rdy = r2;
        enq_fu_sel = fu; enq_rob_idx = rob;
        enq_payload = {$urandom(), $urandom(), $urandom()};
    endtask

    function automatic bit rob_used(input logic [4:0] r);
        foreach (mq[i]) if (mq[i].rob == r) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        logic [4:0] r;
        idle();
        fu_busy = 0; rob_head = 0; issue_ready = 0;
        rst = 1;
        @(negedge clk);
        step(); step();
        idle();
        settle();
        chk("rst_count", iq_count, 0);
        chk("rst_iv", issue_valid, 0);
        tick();

        // Three ready ops issue in rob order, one cycle after the first enqueue
        issue_ready = 1;
        enq(7'd10, 1, 7'd11, 1, FU_ALU, 5'd4); settle(); chk("t1_c0_iv", issue_valid, 0); tick();
        enq(7'd10, 1, 7'd11, 1, FU_ALU, 5'd5); settle(); chk("t1_c1_rob", issue_rob_idx, 4); tick();
        enq(7'd10, 1, 7'd11, 1, FU_ALU, 5'd6); settle(); chk("t1_c2_rob", issue_rob_idx, 5); tick();
        idle(); settle(); chk("t1_c3_rob", issue_rob_idx, 6); tick();
        settle(); chk("t1_count", iq_count, 0); tick();

        // Wakeup in cycle N is selectable in N+1
        enq(7'd12, 0, 7'd0, 0, FU_ALU, 5'd7); step();
        idle(); wk_valid = 2'b01; wk_tag = {7'd0, 7'd12};
        settle(); chk("t2_n_iv", issue_valid, 0); tick();
        idle(); settle(); chk("t2_n1_iv", issue_valid, 1); tick();

        // Age ordering across the rob wrap
        issue_ready = 0; rob_head = 30;
        enq(7'd1, 1, 7'd2, 1, FU_ALU, 5'd31); step();
        enq(7'd1, 1, 7'd2, 1, FU_ALU, 5'd1); step();
        idle(); settle(); chk("t3_head30", issue_rob_idx, 31); tick();
        rob_head = 0; issue_ready = 1;
        settle(); chk("t3_head0", issue_rob_idx, 1); tick();
        settle(); chk("t3_second", issue_rob_idx, 31); tick();

        // Busy FU lets a younger op bypass
        issue_ready = 0;
        enq(7'd3, 1, 7'd4, 1, FU_DIV, 5'd2); step();
        enq(7'd3, 1, 7'd4, 1, FU_ALU, 5'd3); step();
        idle(); fu_busy = 8'h04; issue_ready = 1;
        settle(); chk("t4_young", issue_rob_idx, 3); tick();
        fu_busy = 0; settle(); chk("t4_old", issue_rob_idx, 2); tick();

        // Full queue: a same-cycle issue does not open space for enqueue
        issue_ready = 0;
        for (int i = 0; i < IQ; i++) begin
            enq(7'd5, 1, 7'd6, 1, FU_ALU, 5'(8 + i)); step();
        end
        idle(); settle(); chk("t5_full_rdy", enq_ready, 0); chk("t5_cnt8", iq_count, 8); tick();
        issue_ready = 1; enq(7'd5, 1, 7'd6, 1, FU_ALU, 5'd20);
        settle(); chk("t5_rdy_issue", enq_ready, 0); tick();
        idle(); issue_ready = 0;
        settle(); chk("t5_cnt7", iq_count, 7); chk("t5_rdy_after", enq_ready, 1); tick();
        issue_ready = 1;
        for (int i = 0; i < 7; i++) step();

        // Flush beats same-cycle enqueue and wakeup
        issue_ready = 0;
        for (int i = 0; i < 5; i++) begin
            enq(7'd20, i[0], 7'd21, 1, FU_ALU, 5'(i)); step();
        end
        enq(7'd30, 1, 7'd31, 1, FU_ALU, 5'd9); flush = 1; issue_ready = 1;
        wk_valid = 2'b11; wk_tag = {7'd20, 7'd20};
        settle(); chk("t6_flush_iv", issue_valid, 0); tick();
        idle();
        settle(); chk("t6_cnt", iq_count, 0); chk("t6_empty", iq_empty, 1); chk("t6_iv", issue_valid, 0); tick();

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            idle();
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 2) != 0) begin
                do r = 5'($urandom_range(0, 31)); while (rob_used(r));
                enq(7'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                    7'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
                    3'($urandom_range(0, 7)), r);
            end
            wk_valid    = 2'($urandom_range(0, 3));
            wk_tag      = {7'($urandom_range(0, 15)), 7'($urandom_range(0, 15))};
            fu_busy     = 8'($urandom() & $urandom() & $urandom());
            issue_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 7) == 0) rob_head = 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/issue_sched.md
Name: issue_sched

Overview:
- Unified issue queue and select scheduler between the decode/dispatch stage and register-read/FU issue.
- Holds renamed micro-ops until both physical sources are ready, then wakes them up from writeback tag broadcasts.
- Each cycle, selects the oldest ready entry (by ROB age) whose functional unit is not busy.
- Shares the eight FU classes (0 alu … 7 csr) among all waiting micro-ops through one issue port.

Parameters:
- IQ_LEN, 8, number of queue entries (power of two, ≥2)
- ROB_LEN, 32, ROB depth; rob_idx width is $clog2(ROB_LEN)
- WK_PORTS, 2, number of writeback wakeup broadcast ports
- PAYLOAD_W, 96, opaque per-entry payload (pc/imm/op/f3/f7/P_rd/LQ/SQ tails/jump), carried untouched

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  mispredict flush; kills all entries
- enq_valid  in  1  dispatch offers a micro-op
- enq_ready  out  1  queue can accept a micro-op
- enq_rs1, enq_rs2  in  7 each  physical source tags
- enq_rs1_rdy, enq_rs2_rdy  in  1 each  busy-table ready bits at dispatch
- enq_fu_sel  in  3  FU class
- enq_rob_idx  in  $clog2(ROB_LEN)  ROB slot of the micro-op
- enq_payload  in  PAYLOAD_W  opaque data
- wk_valid  in  WK_PORTS  wakeup strobes
- wk_tag  in  WK_PORTS*7  woken physical tags; port i is bits [7i+6:7i]
- fu_busy  in  8  per-class FU cannot accept this cycle
- rob_head  in  $clog2(ROB_LEN)  oldest ROB slot
- issue_valid  out  1  selected micro-op present
- issue_ready  in  1  register-read stage accepts
- issue_rs1, issue_rs2  out  7 each  physical source tags of the selected entry
- issue_fu_sel  out  3  FU class of the selected entry
- issue_rob_idx  out  $clog2(ROB_LEN)  ROB slot of the selected entry
- issue_payload  out  PAYLOAD_W  payload of the selected entry
- iq_count  out  $clog2(IQ_LEN)+1  occupied entries
- iq_empty  out  1  iq_count == 0

Behaviour:
- Reset: all entry valid bits are 0; iq_count=0, iq_empty=1, enq_ready=1, issue_valid=0, and all issue_* data outputs are 0.
- Entry state: valid, r1, r2, tags, fu_sel, rob_idx, payload. Each entry is a 2-state FSM: FREE → WAIT on enqueue; WAIT → FREE on issue or flush.
- Enqueue:
  - Accepted when enq_valid && enq_ready.
  - enq_ready = (iq_count < IQ_LEN), computed from registered state only; a same-cycle issue does not free space for a same-cycle enqueue.
  - Target slot is the lowest-index FREE entry.
  - r1 = enq_rs1_rdy OR enq_rs1==0 OR a same-cycle wk_valid[i] with wk_tag[i]==enq_rs1; r2 is computed the same way.
- Wakeup: for each resident valid entry, r1/r2 are set when any valid wakeup port matches the tag. Several ports matching in one cycle is legal. Once set, a ready bit never clears.
- Select (combinational):
  - Eligible = valid && r1 && r2 && !fu_busy[fu_sel].
  - Age = (rob_idx - rob_head) mod ROB_LEN; the eligible entry with the smallest age wins.
  - Ties cannot occur; if they do, the lowest index wins.
  - issue_valid = any eligible && !flush.
  - issue_* outputs are driven from the winner; they are 0 when issue_valid=0.
- Latency:
  - An entry enqueued in cycle N is first selectable in N+1.
  - A wakeup in cycle N makes an entry selectable in N+1; there is no same-cycle wake-to-select.
- Issue: on issue_valid && issue_ready, the winner is freed at the clock edge. If issue_ready=0, outputs may change next cycle because an older entry may become eligible; the downstream stage must not assume stability.
- Count: iq_count += enq_fire - issue_fire each cycle.
- Flush: highest priority. All entries are cleared and iq_count=0 next cycle. Same-cycle enqueue and wakeup are ignored and issue_valid is forced to 0.
- rst mid-operation behaves identically to flush and also forces the reset output values.
- Full: with iq_count=IQ_LEN, enq_ready=0 even if an issue fires that cycle.
- Wrap-around: the age computation must be correct across the rob_idx wrap (e.g. rob_head=30, idx 1 is younger than idx 31).

Decomposition:
- Shared package holds:
  - the FU_* class constants (0 ALU … 7 CSR)
  - the iq_entry_t packed struct
  - the PTAG_W=7 constant
- One sub-module, iq_age_select: combinational oldest-eligible picker taking the eligible mask, per-entry rob_idx and rob_head, and returning one-hot grant and index.
- Tag-match/wakeup logic stays inline.

Test Plan:
- Reset, then enqueue three ops with both sources ready (rob 4, 5, 6, fu 0), issue_ready=1 → issued in order rob 4, 5, 6 on consecutive cycles starting one cycle after the first enqueue; iq_count returns to 0.
- Enqueue op rs1=12 not ready, then wk_tag0=12 in cycle N → issue_valid=0 in N, issue_valid=1 in N+1.
- Ready ops rob 31 and rob 1 with rob_head=30 → rob 31 issues first; with rob_head=0 → rob 1 issues first.
- Oldest ready op has fu_sel=2 and fu_busy[2]=1, younger op has fu_sel=0 → younger issues; after fu_busy[2] drops, older issues next cycle.
- Fill to 8 entries: enq_ready=0; issue plus enqueue attempt in the same cycle → enqueue rejected, count 7, enq_ready=1 the following cycle.
- Queue holding 5 entries, flush asserted together with enq_valid and a matching wakeup → issue_valid=0 that cycle; next cycle iq_count=0, iq_empty=1, and no stale issue.
